qsched_instr_loader: RTL

Upstream feeder for the qubit-operation `scheduler`. It accepts a stream of packed instructions over a valid/ready handshake and writes each one into the lowest free slot of a `NUM_INSTRS`-entry instruction register array. It drives that array, plus a per-slot pending mask, directly into the scheduler's `instruction`/`status` inputs. It then launches the batch and holds off new input until the scheduler has retired every pending slot.

---
 rtl/qsched_instr_loader.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/qsched_instr_loader.sv
// Instruction loader feeding the qubit-operation scheduler: fills the lowest free slot, launches, waits for full retire.
// Optional macro QSCHED_LOADER_PERF_EN builds a RUN-phase cycle counter driving run_cycles.
module qsched_instr_loader #(
  parameter int unsigned NUM_FPGA           = 64,
  parameter int unsigned NUM_QUBIT_PER_FPGA = 64,
  parameter int unsigned NUM_INSTRS         = 100,
  localparam int unsigned QW = $clog2(NUM_FPGA * NUM_QUBIT_PER_FPGA),
  localparam int unsigned IW = 3 * QW + 22,
  localparam int unsigned CW = $clog2(NUM_INSTRS + 1),
  localparam int unsigned XW = $clog2(NUM_INSTRS)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [IW-1:0]                    in_instr,
  input  logic                             in_last,
  output logic [0:NUM_INSTRS-1][IW-1:0]    instruction,
  output logic [NUM_INSTRS-1:0]            status,
  output logic [CW-1:0]                    fill_count,
  output logic                             sched_start,
  input  logic                             retire_valid,
  input  logic [XW-1:0]                    retire_index,
  output logic                             batch_done,
  output logic                             err,
  output logic [31:0]                      run_cycles
);

  typedef enum logic [1:0] {S_FILL, S_LAUNCH, S_RUN} state_e;

  state_e                          state_q, state_d;
  logic [NUM_INSTRS-1:0]           status_q, status_d;
  logic [CW-1:0]                   fill_q, fill_d;
  logic [0:NUM_INSTRS-1][IW-1:0]   instr_q;
  logic                            sched_start_q, sched_start_d;
  logic                            batch_done_q, batch_done_d;
  logic                            err_q, err_d;
  logic                            wr_en;
  logic                            free_found;
  logic [XW-1:0]                   free_idx;
  logic                            retire_in_range;
  logic                            retire_ok;

  // Lowest-index free slot; one always exists whenever in_ready is high.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int unsigned i = 0; i < NUM_INSTRS; i++) begin
      if (!free_found && !status_q[XW'(i)]) begin
        free_found = 1'b1;
        free_idx   = XW'(i);
      end
    end
  end

  assign retire_in_range = 32'(retire_index) < NUM_INSTRS;
  assign retire_ok       = retire_valid && (state_q == S_RUN) && retire_in_range
                           && status_q[retire_index];
  assign in_ready        = (state_q == S_FILL) && (fill_q < CW'(NUM_INSTRS));

  always_comb begin
    state_d       = state_q;
    status_d      = status_q;
    fill_d        = fill_q;
    sched_start_d = 1'b0;
    batch_done_d  = 1'b0;
    err_d         = err_q;
    wr_en         = 1'b0;
    if (retire_valid && !retire_ok) err_d = 1'b1;
    unique case (state_q)
      S_FILL: begin
        if (in_valid && in_ready) begin
          wr_en              = 1'b1;
          status_d[free_idx] = 1'b1;
          fill_d             = fill_q + CW'(1);
          if (in_last || (fill_q == CW'(NUM_INSTRS - 1))) begin
            state_d       = S_LAUNCH;
            sched_start_d = 1'b1;
          end
        end
      end
      S_LAUNCH: state_d = S_RUN;
      S_RUN: begin
        if (retire_ok) begin
          status_d[retire_index] = 1'b0;
          fill_d                 = fill_q - CW'(1);
          if (fill_q == CW'(1)) begin
            state_d      = S_FILL;
            batch_done_d = 1'b1;
          end
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_FILL;
      status_q      <= '0;
      fill_q        <= '0;
      sched_start_q <= 1'b0;
      batch_done_q  <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      status_q      <= status_d;
      fill_q        <= fill_d;
      sched_start_q <= sched_start_d;
      batch_done_q  <= batch_done_d;
      err_q         <= err_d;
    end
  end

  // Slot storage keeps stale contents after retire until overwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= '0;
    end else if (wr_en) begin
      instr_q[free_idx] <= in_instr;
    end
  end

  assign instruction = instr_q;
  assign status      = status_q;
  assign fill_count  = fill_q;
  assign sched_start = sched_start_q;
  assign batch_done  = batch_done_q;
  assign err         = err_q;

`ifdef QSCHED_LOADER_PERF_EN
  logic [31:0] cyc_q, cyc_d, cyc_inc;
  logic [31:0] run_cycles_q, run_cycles_d;

  // Counter value plus the current RUN cycle, saturating.
  always_comb begin
    cyc_inc      = (cyc_q == 32'hFFFF_FFFF) ? cyc_q : cyc_q + 32'd1;
    cyc_d        = cyc_q;
    run_cycles_d = run_cycles_q;
    if (state_q == S_LAUNCH) cyc_d = '0;
    else if (state_q == S_RUN) cyc_d = cyc_inc;
    if ((state_q == S_RUN) && (state_d == S_FILL)) run_cycles_d = cyc_inc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q        <= '0;
      run_cycles_q <= '0;
    end else begin
      cyc_q        <= cyc_d;
      run_cycles_q <= run_cycles_d;
    end
  end

  assign run_cycles = run_cycles_q;
`else
  assign run_cycles = '0;
`endif

endmodule
